// File: rtl/qpsk_pkg.sv
// Shared types, default constants and the Gray symbol map for the QPSK modem.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package qpsk_pkg;

    typedef logic [1:0]          qpsk_sym_t;
    typedef logic signed [15:0]  qpsk_sample_t;

    typedef struct packed {
        qpsk_sample_t i;
        qpsk_sample_t q;
    } qpsk_iq_t;

    localparam qpsk_sample_t QPSK_AMP       = 16'sd23170;  // ~0.707 full scale
    localparam qpsk_sample_t QPSK_ERASE_THR = 16'sd4096;

    // Gray map: b1 -> I, b0 -> Q; a 0 bit is +amp, a 1 bit is -amp.
    // amp is 1..32767, so -amp never overflows.
    function automatic qpsk_iq_t qpsk_map(input qpsk_sym_t sym, input qpsk_sample_t amp);
        qpsk_iq_t iq;
        iq.i = sym[1] ? -amp : amp;
        iq.q = sym[0] ? -amp : amp;
        return iq;
    endfunction

endpackage

// File: rtl/qpsk_slicer.sv
// Per-axis hard decision: sign bit of the sample, plus low-confidence flag.
// Latency: combinational (the top registers the result).
// Backpressure: none.
// Ports: sample (signed 16) in; sign_bit out (1 = negative; 0 decides bit 0);
//        low_conf out (|sample| < THR) only when QPSK_ERASURE_EN is defined.
module qpsk_slicer
    import qpsk_pkg::*;
#(
    parameter qpsk_sample_t THR = QPSK_ERASE_THR
) (
    input  qpsk_sample_t sample,
`ifdef QPSK_ERASURE_EN
    output logic         low_conf,
`endif
    output logic         sign_bit
);

    // Zero counts as positive, so the sign bit alone is the decision.
    assign sign_bit = sample[15];

`ifdef QPSK_ERASURE_EN
    qpsk_sample_t mag;

    // -32768 has no positive twin in 16 bits; clamp it to 32767.
    always_comb begin
        mag = sample;
        if (sample == 16'sh8000) begin
            mag = 16'sd32767;
        end else if (sample[15]) begin
            mag = -sample;
        end
    end

    assign low_conf = (mag < THR);
`endif

endmodule

// File: rtl/qpsk_modem.sv
// Gray-mapped QPSK symbol mapper (mod) and hard-decision slicer (demod); paths are independent.
// Latency: 1 cycle on each path; outputs hold their last value when the input valid is low.
// Backpressure: none -- a new symbol/sample is accepted every cycle.
// Ports: clk, rst (async active-low);
//        mod_valid_i/mod_data_i[1:0] -> mod_valid_o/mod_i_o[15:0]/mod_q_o[15:0];
//        demod_valid_i/demod_i_i[15:0]/demod_q_i[15:0] -> demod_valid_o/demod_data_o[1:0]/demod_erase_o.
// Build option: QPSK_ERASURE_EN enables the registered erasure flag; otherwise demod_erase_o is 0.
module qpsk_modem
    import qpsk_pkg::*;
#(
    parameter qpsk_sample_t AMP       = QPSK_AMP,
    parameter qpsk_sample_t ERASE_THR = QPSK_ERASE_THR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mod_valid_i,
    input  logic [1:0]  mod_data_i,
    output logic        mod_valid_o,
    output logic [15:0] mod_i_o,
    output logic [15:0] mod_q_o,
    input  logic        demod_valid_i,
    input  logic [15:0] demod_i_i,
    input  logic [15:0] demod_q_i,
    output logic        demod_valid_o,
    output logic [1:0]  demod_data_o,
    output logic        demod_erase_o
);

    // Elaboration-time parameter sanity checks.
    if (AMP < 16'sd1) begin : g_amp_range
        $error("qpsk_modem: AMP must be in 1..32767");
    end
    if (ERASE_THR < 16'sd0) begin : g_thr_range
        $error("qpsk_modem: ERASE_THR must be non-negative");
    end

    // ---------------- mod path ----------------
    qpsk_iq_t mod_iq;
    assign mod_iq = qpsk_map(qpsk_sym_t'(mod_data_i), AMP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mod_valid_o <= 1'b0;
            mod_i_o     <= '0;
            mod_q_o     <= '0;
        end else begin
            mod_valid_o <= mod_valid_i;
            if (mod_valid_i) begin
                mod_i_o <= mod_iq.i;
                mod_q_o <= mod_iq.q;
            end
        end
    end

    // ---------------- demod path ----------------
    logic bit_i;
    logic bit_q;

`ifdef QPSK_ERASURE_EN
    logic low_i;
    logic low_q;

    qpsk_slicer #(.THR(ERASE_THR)) u_slice_i (
        .sample   (qpsk_sample_t'(demod_i_i)),
        .low_conf (low_i),
        .sign_bit (bit_i)
    );

    qpsk_slicer #(.THR(ERASE_THR)) u_slice_q (
        .sample   (qpsk_sample_t'(demod_q_i)),
        .low_conf (low_q),
        .sign_bit (bit_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            demod_erase_o <= 1'b0;
        end else if (demod_valid_i) begin
            demod_erase_o <= low_i | low_q;
        end
    end
`else
    qpsk_slicer #(.THR(ERASE_THR)) u_slice_i (
        .sample   (qpsk_sample_t'(demod_i_i)),
        .sign_bit (bit_i)
    );

    qpsk_slicer #(.THR(ERASE_THR)) u_slice_q (
        .sample   (qpsk_sample_t'(demod_q_i)),
        .sign_bit (bit_q)
    );

    assign demod_erase_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            demod_valid_o <= 1'b0;
            demod_data_o  <= '0;
        end else begin
            demod_valid_o <= demod_valid_i;
            if (demod_valid_i) begin
                demod_data_o <= {bit_i, bit_q};
            end
        end
    end

endmodule

// File: tb/tb_qpsk_modem.sv
// Directed, table-driven bench for qpsk_modem: reset, mapping, loopback, slicer edges, valid gaps, mid-stream reset.
// Latency: checks 1-cycle mod/demod and 2-cycle loopback.
// Backpressure: n/a (the DUT has none).
module tb_qpsk_modem;

`ifdef QPSK_ERASURE_EN
    localparam bit ERASE_ON = 1'b1;
`else
    localparam bit ERASE_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mod_valid_i;
    logic [1:0]  mod_data_i;
    logic        mod_valid_o;
    logic [15:0] mod_i_o;
    logic [15:0] mod_q_o;
    logic        demod_valid_i;
    logic [15:0] demod_i_i;
    logic [15:0] demod_q_i;
    logic        demod_valid_o;
    logic [1:0]  demod_data_o;
    logic        demod_erase_o;

    // Bench-side demod drive, optionally replaced by the mod outputs (loopback).
    logic        loop_en;
    logic        drv_dv;
    logic [15:0] drv_di;
    logic [15:0] drv_dq;

    assign demod_valid_i = loop_en ? mod_valid_o : drv_dv;
    assign demod_i_i     = loop_en ? mod_i_o     : drv_di;
    assign demod_q_i     = loop_en ? mod_q_o     : drv_dq;

    qpsk_modem dut (
        .clk           (clk),
        .rst           (rst),
        .mod_valid_i   (mod_valid_i),
        .mod_data_i    (mod_data_i),
        .mod_valid_o   (mod_valid_o),
        .mod_i_o       (mod_i_o),
        .mod_q_o       (mod_q_o),
        .demod_valid_i (demod_valid_i),
        .demod_i_i     (demod_i_i),
        .demod_q_i     (demod_q_i),
        .demod_valid_o (demod_valid_o),
        .demod_data_o  (demod_data_o),
        .demod_erase_o (demod_erase_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] sym;
        int         exp_i;
        int         exp_q;
    } map_vec_t;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [1:0]  exp_sym;
        logic        exp_erase;
    } slice_vec_t;

    map_vec_t   map_tab [4];
    slice_vec_t slc_tab [7];
    logic [1:0] loop_exp [8];
    logic [15:0] loop_word;

    // Expected mod output for a symbol, with the default amplitude.
    function automatic int exp_amp(input logic b);
        return b ? -23170 : 23170;
    endfunction

    initial begin
        map_tab[0] = '{2'b00,  23170,  23170};
        map_tab[1] = '{2'b01,  23170, -23170};
        map_tab[2] = '{2'b10, -23170,  23170};
        map_tab[3] = '{2'b11, -23170, -23170};

        slc_tab[0] = '{16'sd0,      16'sd0,      2'b00, 1'b1};
        slc_tab[1] = '{-16'sd1,     16'sd1,      2'b10, 1'b1};
        slc_tab[2] = '{16'sh8000,   16'sd32767,  2'b10, 1'b0};
        slc_tab[3] = '{16'sd1,      16'sh8000,   2'b01, 1'b1};
        slc_tab[4] = '{16'sd4095,   16'sd20000,  2'b00, 1'b1};
        slc_tab[5] = '{16'sd4096,   -16'sd4096,  2'b01, 1'b0};
        slc_tab[6] = '{16'sh8000,   16'sd0,      2'b10, 1'b1};

        loop_exp = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b11};
        loop_word = 16'b1110110110001101;

        rst = 1'b0;
        loop_en = 1'b0;
        mod_valid_i = 1'b0;
        mod_data_i = 2'b00;
        drv_dv = 1'b0;
        drv_di = '0;
        drv_dq = '0;

        // ---- reset held with random inputs ----
        for (int c = 0; c < 4; c++) begin
            mod_valid_i = 1'($urandom);
            mod_data_i  = 2'($urandom);
            drv_dv      = 1'($urandom);
            drv_di      = 16'($urandom);
            drv_dq      = 16'($urandom);
            step();
            check("rst_mod_valid", mod_valid_o, 0);
            check("rst_mod_i", $signed(mod_i_o), 0);
            check("rst_mod_q", $signed(mod_q_o), 0);
            check("rst_demod_valid", demod_valid_o, 0);
            check("rst_demod_data", demod_data_o, 0);
            check("rst_demod_erase", demod_erase_o, 0);
        end

        // ---- release with no valids: outputs stay 0 ----
        mod_valid_i = 1'b0;
        drv_dv = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check("post_rst_mod_valid", mod_valid_o, 0);
            check("post_rst_mod_i", $signed(mod_i_o), 0);
            check("post_rst_demod_valid", demod_valid_o, 0);
            check("post_rst_demod_data", demod_data_o, 0);
        end

        // ---- mapping sweep ----
        for (int k = 0; k < 4; k++) begin
            mod_valid_i = 1'b1;
            mod_data_i  = map_tab[k].sym;
            step();
            check("map_valid", mod_valid_o, 1);
            check("map_i", $signed(mod_i_o), map_tab[k].exp_i);
            check("map_q", $signed(mod_q_o), map_tab[k].exp_q);
        end
        mod_valid_i = 1'b0;
        step();

        // ---- slicer edges and erasure thresholds ----
        for (int k = 0; k < 7; k++) begin
            drv_dv = 1'b1;
            drv_di = slc_tab[k].i;
            drv_dq = slc_tab[k].q;
            step();
            check("slice_valid", demod_valid_o, 1);
            check("slice_data", demod_data_o, slc_tab[k].exp_sym);
            check("slice_erase", demod_erase_o, ERASE_ON ? slc_tab[k].exp_erase : 1'b0);
        end

        // ---- demod hold on invalid ----
        drv_dv = 1'b0;
        drv_di = 16'sd100;
        drv_dq = -16'sd100;
        step();
        check("demod_hold_valid", demod_valid_o, 0);
        check("demod_hold_data", demod_data_o, 2'b10);
        check("demod_hold_erase", demod_erase_o, ERASE_ON ? 1'b1 : 1'b0);

        // ---- loopback stream ----
        loop_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                mod_valid_i = 1'b1;
                mod_data_i  = loop_word[2*k +: 2];
            end else begin
                mod_valid_i = 1'b0;
                mod_data_i  = 2'b00;
            end
            step();
            if (k >= 1 && k <= 8) begin
                check("loop_valid", demod_valid_o, 1);
                check("loop_data", demod_data_o, loop_exp[k-1]);
            end else if (k == 9) begin
                check("loop_tail_valid", demod_valid_o, 0);
                check("loop_tail_hold", demod_data_o, loop_exp[7]);
            end
        end
        loop_en = 1'b0;

        // ---- valid gaps on the mod path ----
        for (int k = 0; k < 4; k++) begin
            logic [1:0] s;
            s = map_tab[3-k].sym;
            mod_valid_i = 1'b1;
            mod_data_i  = s;
            step();
            check("gap_on_valid", mod_valid_o, 1);
            check("gap_on_i", $signed(mod_i_o), exp_amp(s[1]));
            check("gap_on_q", $signed(mod_q_o), exp_amp(s[0]));
            mod_valid_i = 1'b0;
            mod_data_i  = ~s;
            step();
            check("gap_off_valid", mod_valid_o, 0);
            check("gap_off_i", $signed(mod_i_o), exp_amp(s[1]));
            check("gap_off_q", $signed(mod_q_o), exp_amp(s[0]));
        end

        // ---- reset mid-stream: async clear, fresh start afterwards ----
        mod_valid_i = 1'b1;
        mod_data_i  = 2'b01;
        drv_dv = 1'b1;
        drv_di = -16'sd5000;
        drv_dq = -16'sd5000;
        step();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_mod_valid", mod_valid_o, 0);
        check("midrst_mod_i", $signed(mod_i_o), 0);
        check("midrst_mod_q", $signed(mod_q_o), 0);
        check("midrst_demod_valid", demod_valid_o, 0);
        check("midrst_demod_data", demod_data_o, 0);
        step();
        mod_valid_i = 1'b0;
        drv_dv = 1'b0;
        rst = 1'b1;
        step();
        check("restart_idle_valid", mod_valid_o, 0);
        check("restart_idle_i", $signed(mod_i_o), 0);
        check("restart_idle_demod", demod_data_o, 0);
        mod_valid_i = 1'b1;
        mod_data_i  = 2'b11;
        step();
        check("restart_valid", mod_valid_o, 1);
        check("restart_i", $signed(mod_i_o), -23170);
        check("restart_q", $signed(mod_q_o), -23170);
        mod_valid_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
